// File: rtl/rx_deframer.sv
// rx_deframer: hunts a zero preamble + SFD in the recovered bit stream, reads the PHR length, packs payload into nibbles.
// Latency: 1 cycle from the deciding strobed bit to any pulse, FIFO write or o_locked change.
// Backpressure: i_fifo_full sampled on the nibble-completing bit; if set, nibble is dropped, o_err_ovf pulses, frame abandoned.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_data, i_flag          recovered bit and its one-cycle valid strobe
//   i_fifo_full             output FIFO full
//   o_data, o_wr_en         payload nibble (bit0 earliest) and its write strobe
//   o_len                   payload length in bytes from the last accepted PHR
//   o_frame_start/_done     framing pulses
//   o_err_len, o_err_ovf    zero-length PHR / dropped-nibble pulses
//   o_locked                high while in PHR or PAYLOAD
module rx_deframer #(
    parameter int          PRE_BITS = 8,
    parameter logic [7:0]  SFD      = 8'hA7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_data,
    input  logic       i_flag,
    input  logic       i_fifo_full,
    output logic [3:0] o_data,
    output logic       o_wr_en,
    output logic [6:0] o_len,
    output logic       o_frame_start,
    output logic       o_frame_done,
    output logic       o_err_len,
    output logic       o_err_ovf,
    output logic       o_locked
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SFD     = 2'd1,
        ST_PHR     = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    localparam logic [5:0] PRE_CNT = 6'(PRE_BITS);

    state_t     state_q, state_d;
    logic [5:0] zcnt_q, zcnt_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] ncnt_q, ncnt_d;
    logic [6:0] len_q, len_d;
    logic [3:0] data_q, data_d;
    logic       wr_q, wr_d;
    logic       start_q, start_d;
    logic       done_q, done_d;
    logic       errlen_q, errlen_d;
    logic       errovf_q, errovf_d;
    logic       locked_q, locked_d;

    // Shift register fills from the top so that after 8 (or 4) bits the
    // earliest bit sits at bit0 of the byte (or of sr[7:4] for a nibble).
    logic [7:0] byte_in;
    logic [5:0] zcnt_inc;
    logic [7:0] ncnt_inc;

    assign byte_in  = {i_data, sr_q[7:1]};
    assign zcnt_inc = zcnt_q + 6'd1;
    assign ncnt_inc = ncnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        zcnt_d   = zcnt_q;
        sr_d     = sr_q;
        bcnt_d   = bcnt_q;
        ncnt_d   = ncnt_q;
        len_d    = len_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        start_d  = 1'b0;
        done_d   = 1'b0;
        errlen_d = 1'b0;
        errovf_d = 1'b0;
        locked_d = locked_q;

        if (i_flag) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (i_data) begin
                        zcnt_d = 6'd0;
                    end else if (zcnt_inc == PRE_CNT) begin
                        state_d = ST_SFD;
                        zcnt_d  = 6'd0;
                        sr_d    = 8'd0;
                        bcnt_d  = 3'd0;
                    end else begin
                        zcnt_d = zcnt_inc;
                    end
                end

                ST_SFD: begin
                    // Zeros before the first one are still preamble.
                    if (bcnt_q != 3'd0 || i_data) begin
                        sr_d   = byte_in;
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            bcnt_d = 3'd0;
                            sr_d   = 8'd0;
                            if (byte_in == SFD) begin
                                state_d  = ST_PHR;
                                locked_d = 1'b1;
                            end else begin
                                state_d = ST_HUNT;
                                zcnt_d  = 6'd0;
                            end
                        end
                    end
                end

                ST_PHR: begin
                    sr_d   = byte_in;
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        bcnt_d = 3'd0;
                        sr_d   = 8'd0;
                        // phr[7] is reserved and ignored.
                        if (byte_in[6:0] == 7'd0) begin
                            errlen_d = 1'b1;
                            state_d  = ST_HUNT;
                            zcnt_d   = 6'd0;
                            locked_d = 1'b0;
                        end else begin
                            len_d   = byte_in[6:0];
                            start_d = 1'b1;
                            ncnt_d  = 8'd0;
                            state_d = ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    sr_d = byte_in;
                    if (bcnt_q[1:0] == 2'd3) begin
                        bcnt_d = 3'd0;
                        if (i_fifo_full) begin
                            errovf_d = 1'b1;
                            state_d  = ST_HUNT;
                            zcnt_d   = 6'd0;
                            locked_d = 1'b0;
                        end else begin
                            data_d = byte_in[7:4];
                            wr_d   = 1'b1;
                            ncnt_d = ncnt_inc;
                            if (ncnt_inc == {len_q, 1'b0}) begin
                                done_d   = 1'b1;
                                state_d  = ST_HUNT;
                                zcnt_d   = 6'd0;
                                locked_d = 1'b0;
                            end
                        end
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    zcnt_d  = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_HUNT;
            zcnt_q   <= 6'd0;
            sr_q     <= 8'd0;
            bcnt_q   <= 3'd0;
            ncnt_q   <= 8'd0;
            len_q    <= 7'd0;
            data_q   <= 4'd0;
            wr_q     <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            errlen_q <= 1'b0;
            errovf_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            zcnt_q   <= zcnt_d;
            sr_q     <= sr_d;
            bcnt_q   <= bcnt_d;
            ncnt_q   <= ncnt_d;
            len_q    <= len_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            start_q  <= start_d;
            done_q   <= done_d;
            errlen_q <= errlen_d;
            errovf_q <= errovf_d;
            locked_q <= locked_d;
        end
    end

    assign o_data        = data_q;
    assign o_wr_en       = wr_q;
    assign o_len         = len_q;
    assign o_frame_start = start_q;
    assign o_frame_done  = done_q;
    assign o_err_len     = errlen_q;
    assign o_err_ovf     = errovf_q;
    assign o_locked      = locked_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Self-checking bench for rx_deframer: drives framed bit streams, scoreboards FIFO writes.
// Expected nibbles are queued as the nibble-completing bit is driven and popped on each o_wr_en.
// Event pulses are counted and compared with bench-side expected counts after each scenario.
module tb_rx_deframer;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_data;
    logic       i_flag;
    logic       i_fifo_full;
    logic [3:0] o_data;
    logic       o_wr_en;
    logic [6:0] o_len;
    logic       o_frame_start;
    logic       o_frame_done;
    logic       o_err_len;
    logic       o_err_ovf;
    logic       o_locked;

    rx_deframer #(.PRE_BITS(8), .SFD(8'hA7)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_data        (i_data),
        .i_flag        (i_flag),
        .i_fifo_full   (i_fifo_full),
        .o_data        (o_data),
        .o_wr_en       (o_wr_en),
        .o_len         (o_len),
        .o_frame_start (o_frame_start),
        .o_frame_done  (o_frame_done),
        .o_err_len     (o_err_len),
        .o_err_ovf     (o_err_ovf),
        .o_locked      (o_locked)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard entry: {frame_done, nibble}
    logic [4:0] exp_q[$];

    int   n_start = 0, n_done = 0, n_errlen = 0, n_ovf = 0, n_lock = 0;
    int   e_start = 0, e_done = 0, e_errlen = 0, e_ovf = 0, e_lock = 0;
    logic [6:0] exp_len = 7'd0;
    bit   mon_en = 1'b0;
    bit   spacing_en = 1'b0;
    bit   have_prev = 1'b0;
    int   cyc = 0;
    int   prev_wr_cyc = 0;
    logic prev_locked = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (i_rst_n && mon_en) begin
            if (o_locked && !prev_locked) n_lock++;
            if (o_frame_start) begin
                n_start++;
                check_eq("start_len", 32'(o_len), 32'(exp_len));
            end
            if (o_err_len) n_errlen++;
            if (o_err_ovf) n_ovf++;
            if (o_frame_done) begin
                n_done++;
                check_eq("done_with_wr", 32'(o_wr_en), 32'd1);
            end
            if (o_wr_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_wr", 32'(o_data), 32'hFFFF_FFFF);
                end else begin
                    logic [4:0] item;
                    item = exp_q.pop_front();
                    check_eq("wr_data", 32'(o_data), 32'(item[3:0]));
                    check_eq("wr_done", 32'(o_frame_done), 32'(item[4]));
                end
                if (spacing_en) begin
                    if (have_prev) check_eq("wr_spacing", 32'(cyc - prev_wr_cyc), 32'd12);
                    have_prev = 1'b1;
                    prev_wr_cyc = cyc;
                end
            end
        end
        prev_locked = i_rst_n ? o_locked : 1'b0;
    end

    // One strobed bit followed by `gap` unstrobed cycles of random data.
    task automatic send_bit(input logic b, input int gap);
        i_flag = 1'b1;
        i_data = b;
        @(negedge i_clk);
        i_flag      = 1'b0;
        i_fifo_full = 1'b0;
        repeat (gap) begin
            i_data = 1'($urandom);
            @(negedge i_clk);
        end
    endtask

    // Preamble + SFD; if exp_lock, also PHR and up to pay_bits of payload 0x5A,0xC3.
    task automatic send_frame(input int npre, input logic [7:0] sfd_b, input logic [7:0] phr,
                              input int gap, input int full_nib, input int pay_bits,
                              input bit exp_lock);
        logic [7:0] pay [2];
        logic [6:0] len;
        logic [3:0] nib;
        bit         abandoned;
        int         k;
        pay[0] = 8'h5A;
        pay[1] = 8'hC3;
        len = phr[6:0];
        abandoned = 1'b0;
        for (int i = 0; i < npre; i++) send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(sfd_b[i], gap);
        if (exp_lock) begin
            e_lock++;
            if (len == 7'd0) e_errlen++;
            else begin
                e_start++;
                exp_len = len;
            end
            for (int i = 0; i < 8; i++) send_bit(phr[i], gap);
            if (len != 7'd0) begin
                for (int j = 0; j < pay_bits && j < 16; j++) begin
                    k = j / 4;
                    if ((j % 4) == 3 && !abandoned) begin
                        nib = 4'(pay[k / 2] >> (4 * (k % 2)));
                        if (k == full_nib) begin
                            i_fifo_full = 1'b1;
                            e_ovf++;
                            abandoned = 1'b1;
                        end else begin
                            exp_q.push_back({(k == 2 * int'(len) - 1), nib});
                            if (k == 2 * int'(len) - 1) e_done++;
                        end
                    end
                    send_bit(pay[j / 8][j % 8], gap);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        i_flag = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic end_checks(input string tag);
        idle(6);
        check_eq({tag, "_starts"}, 32'(n_start), 32'(e_start));
        check_eq({tag, "_dones"}, 32'(n_done), 32'(e_done));
        check_eq({tag, "_errlen"}, 32'(n_errlen), 32'(e_errlen));
        check_eq({tag, "_ovf"}, 32'(n_ovf), 32'(e_ovf));
        check_eq({tag, "_locks"}, 32'(n_lock), 32'(e_lock));
        check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_unlocked"}, 32'(o_locked), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_outs"},
                 32'({o_data, o_wr_en, o_len, o_frame_start, o_frame_done, o_err_len, o_err_ovf}),
                 32'd0);
        check_eq({tag, "_locked"}, 32'(o_locked), 32'd0);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_data      = 1'b0;
        i_flag      = 1'b0;
        i_fifo_full = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("por");
        i_rst_n = 1'b1;

        // Random stimulus, then asynchronous reset in the middle of it.
        for (int i = 0; i < 150; i++) begin
            i_flag      = 1'($urandom);
            i_data      = 1'($urandom);
            i_fifo_full = 1'($urandom);
            @(negedge i_clk);
        end
        #2 i_rst_n = 1'b0;
        #1 check_reset_outputs("rand_rst");
        i_flag = 1'b0;
        i_fifo_full = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Nominal frame, strobe every cycle.
        send_frame(32, 8'hA7, 8'h02, 0, -1, 16, 1'b1);
        end_checks("nominal");
        check_eq("len_latched", 32'(o_len), 32'd2);

        // Gapped strobe: one bit every 3 cycles.
        spacing_en = 1'b1;
        have_prev  = 1'b0;
        send_frame(32, 8'hA7, 8'h02, 2, -1, 16, 1'b1);
        end_checks("gapped");
        spacing_en = 1'b0;

        // Short preamble, wrong SFD, then a good frame.
        send_frame(7, 8'hA7, 8'h00, 0, -1, 0, 1'b0);
        send_frame(8, 8'hA6, 8'h00, 0, -1, 0, 1'b0);
        end_checks("reject");
        send_frame(32, 8'hA7, 8'h02, 0, -1, 16, 1'b1);
        end_checks("after_reject");

        // Zero-length PHR (bit7 set, len field 0), then a good frame.
        send_frame(16, 8'hA7, 8'h80, 0, -1, 0, 1'b1);
        idle(2);
        check_eq("len_hold", 32'(o_len), 32'd2);
        end_checks("len_err");
        send_frame(32, 8'hA7, 8'h02, 0, -1, 16, 1'b1);
        end_checks("after_len_err");

        // FIFO full when the third nibble completes.
        send_frame(32, 8'hA7, 8'h02, 0, 2, 16, 1'b1);
        end_checks("overflow");

        // Reset two bits into the third nibble, then a full frame.
        send_frame(32, 8'hA7, 8'h02, 0, -1, 10, 1'b1);
        #2 i_rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        check_eq("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
        idle(2);
        send_frame(32, 8'hA7, 8'h02, 0, -1, 16, 1'b1);
        end_checks("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
